bcd2bin_seq: RTL and testbench
==============================

Name: bcd2bin_seq

Overview:
Sequential BCD-to-binary converter, the inverse of the combinational binary-to-BCD block. It takes a 3-digit BCD value (hundreds 0-2, tens, ones) and produces the 8-bit binary equivalent. It uses a reverse double-dabble algorithm: shift right, then subtract 3 from every BCD digit that is >= 8. It sits on the display/keypad input path and returns entered decimal values to binary datapaths, using a start/done handshake.

Parameters:
None. Widths are fixed: 2-bit hundreds digit, 4-bit tens, 4-bit ones, 8-bit result, 8 shift iterations.

Ports:
clk          input   1  rising-edge clock
rst_n        input   1  asynchronous active-low reset
start        input   1  request conversion; sampled only in IDLE
bcdHundreds  input   2  hundreds digit, valid 0..2
bcdTens      input   4  tens digit, valid 0..9
bcdOnes      input   4  ones digit, valid 0..9
busy         output  1  high while a conversion is in progress (SHIFT or DONE)
done         output  1  one-cycle pulse when bin/err are updated
err          output  1  error flag for the last conversion; held until the next done
bin          output  8  binary result; held until the next done

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - rst_n low forces, immediately: state=IDLE, busy=0, done=0, err=0, bin=0, shift count=0, internal shift register cleared.
  - Reset in the middle of a conversion aborts it; no done is produced.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - busy=0, done=0.
  - On a clock edge with start=1, the digits are captured and validated.
  - Input is invalid if any of: tens>9; ones>9; hundreds=3; hundreds=2 and tens*10+ones>55.
  - Valid input: load the 18-bit work register {hundreds, tens, ones, 8'b0}, set count=0, go to SHIFT.
  - Invalid input: set the pending error flag, go to DONE (no shifting).
- SHIFT, one iteration per clock:
  - Logically shift the work register right by 1.
  - Then, for each BCD digit field of the shifted value (hundreds is zero-extended to 4 bits), if the field >= 8, subtract 3 from it.
  - count increments; after the 8th iteration (count=7 -> wrap), go to DONE.
- DONE (one cycle):
  - done=1.
  - bin = low 8 bits of the work register, or 0 if the pending error flag is set.
  - err = pending error flag.
  - Next state: IDLE. bin and err are registered and hold until the next DONE.
- Latency:
  - Valid input: start sampled at edge N, done high during the cycle after edge N+9, i.e. 9 cycles.
  - Invalid input: done high during the cycle after edge N+1.
- busy is high from the edge that accepts start through the DONE cycle inclusive.
- start while busy=1 is ignored; no queueing. start held high continuously produces back-to-back conversions: each DONE returns to IDLE, and the next start is accepted one cycle later.
- Digit inputs are sampled only on the accepting edge. Changes during busy have no effect.
- Arithmetic:
  - Field subtract-3 is 4-bit, applied only when field >= 8, so no underflow can occur.
  - After 8 iterations the upper BCD fields are guaranteed zero for valid input. This is an internal assertion and is not checked at runtime.

Test Plan:
- Reset, then start with {1,3,7} -> busy high for 9 cycles; done pulse 9 cycles after start; bin=0x89, err=0.
- Boundary values {0,0,0} -> bin=0x00. {2,5,5} -> bin=0xFF. {0,9,9} -> bin=0x63. err=0 in all cases.
- Invalid inputs {2,5,6}, {3,0,0} and {0,10,0} -> done 1 cycle after start; err=1, bin=0x00. A following valid {0,4,2} clears err to 0 with bin=0x2A.
- Start pulsed again 3 cycles into a {1,0,0} conversion, with the digits changed to {0,0,1} -> ignored; the single done gives bin=0x64.
- rst_n dropped asynchronously mid-SHIFT -> outputs are 0 immediately; no done appears. A new start of {0,1,2} after release -> bin=0x0C.
- start held high with constant {1,2,8} -> done pulses every 10 cycles, each with bin=0x80; bin stays stable between pulses.

Source files
------------

// File: rtl/bcd2bin_seq.sv
// Sequential 3-digit BCD to 8-bit binary converter (reverse double-dabble).
// The start/done handshake returns the result with an error flag for out-of-range digits.
module bcd2bin_seq (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [1:0] bcdHundreds,
    input  logic [3:0] bcdTens,
    input  logic [3:0] bcdOnes,
    output logic       busy,
    output logic       done,
    output logic       err,
    output logic [7:0] bin
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t      state_reg;
    logic [19:0] work_reg;
    logic [2:0]  count_reg;
    logic        err_pend_reg;

    logic [19:0] shift_ext;
    logic [19:0] work_next;
    logic [7:0]  tens_ones;
    logic        input_bad;

    assign tens_ones = ({4'd0, bcdTens} * 8'd10) + {4'd0, bcdOnes};
    assign input_bad = (bcdTens > 4'd9) || (bcdOnes > 4'd9) || (bcdHundreds == 2'd3) ||
                       ((bcdHundreds == 2'd2) && (tens_ones > 8'd55));

    // Work register carries the hundreds digit zero-extended to a full nibble,
    // so all three BCD fields get the same correction after each shift.
    assign shift_ext = {1'b0, work_reg[19:1]};
    assign work_next[7:0] = shift_ext[7:0];

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_fix
            logic [3:0] field;
            assign field = shift_ext[8 + 4*gi +: 4];
            assign work_next[8 + 4*gi +: 4] = (field >= 4'd8) ? (field - 4'd3) : field;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            work_reg     <= '0;
            count_reg    <= '0;
            err_pend_reg <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            err          <= 1'b0;
            bin          <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (input_bad) begin
                            err_pend_reg <= 1'b1;
                            state_reg    <= DONE;
                        end else begin
                            err_pend_reg <= 1'b0;
                            work_reg     <= {2'b00, bcdHundreds, bcdTens, bcdOnes, 8'h00};
                            count_reg    <= '0;
                            state_reg    <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    work_reg  <= work_next;
                    count_reg <= count_reg + 3'd1;
                    if (count_reg == 3'd7)
                        state_reg <= DONE;
                end
                DONE: begin
                    done      <= 1'b1;
                    busy      <= 1'b0;
                    err       <= err_pend_reg;
                    bin       <= err_pend_reg ? 8'h00 : work_reg[7:0];
                    state_reg <= IDLE;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bcd2bin_seq.sv
// Directed bench for bcd2bin_seq: a scoreboard queue holds expected {err,bin}
// per accepted start, and a negedge monitor pops and compares on each done pulse.
module tb_bcd2bin_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start;
    logic [1:0] h;
    logic [3:0] t;
    logic [3:0] o;
    logic       busy;
    logic       done;
    logic       err;
    logic [7:0] bin;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb_q[$];
    logic [7:0] last_bin = 8'h00;
    logic       last_err = 1'b0;

    bcd2bin_seq dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .bcdHundreds(h),
        .bcdTens    (t),
        .bcdOnes    (o),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .bin        (bin)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Result monitor: compares on done, and checks bin/err hold steady otherwise.
    always @(negedge clk) begin
        logic [8:0] exp;
        if (rst_n !== 1'b1) begin
            last_bin = 8'h00;
            last_err = 1'b0;
        end else if (done === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", sb_q.size(), 1);
            end else begin
                exp = sb_q.pop_front();
                check("done_err", err, exp[8]);
                check("done_bin", bin, exp[7:0]);
                $display("done: bin=0x%02h err=%0b (expected 0x%02h/%0b)", bin, err, exp[7:0], exp[8]);
                last_bin = exp[7:0];
                last_err = exp[8];
            end
        end else begin
            check("bin_hold", bin, last_bin);
            check("err_hold", err, last_err);
        end
    end

    task automatic conv(input logic [1:0] hh, input logic [3:0] tt, input logic [3:0] oo,
                        input logic e, input logic [7:0] b, input int lat, input string tag);
        int n;
        int bc;
        @(negedge clk);
        h = hh; t = tt; o = oo; start = 1'b1;
        sb_q.push_back({e, b});
        @(posedge clk);
        #1 start = 1'b0;
        h = 2'd3; t = 4'hF; o = 4'hF;
        bc = (busy === 1'b1) ? 1 : 0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
            if (busy === 1'b1) bc++;
        end
        check({tag, "_latency"}, n, lat);
        check({tag, "_busy_cycles"}, bc, lat);
        @(negedge clk);
    endtask

    initial begin
        int n;
        int dcount;
        start = 1'b0; h = 2'd0; t = 4'd0; o = 4'd0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_bin", bin, 0);
        @(negedge clk) rst_n = 1'b1;

        conv(2'd1, 4'd3, 4'd7, 1'b0, 8'h89, 9, "c137");
        conv(2'd0, 4'd0, 4'd0, 1'b0, 8'h00, 9, "c000");
        conv(2'd2, 4'd5, 4'd5, 1'b0, 8'hFF, 9, "c255");
        conv(2'd0, 4'd9, 4'd9, 1'b0, 8'h63, 9, "c099");
        conv(2'd2, 4'd5, 4'd6, 1'b1, 8'h00, 1, "c256");
        conv(2'd3, 4'd0, 4'd0, 1'b1, 8'h00, 1, "c300");
        conv(2'd0, 4'd10, 4'd0, 1'b1, 8'h00, 1, "c0a0");
        conv(2'd0, 4'd4, 4'd2, 1'b0, 8'h2A, 9, "c042");

        // Second start while busy must be ignored
        @(negedge clk);
        h = 2'd1; t = 4'd0; o = 4'd0; start = 1'b1;
        sb_q.push_back({1'b0, 8'h64});
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        h = 2'd0; t = 4'd0; o = 4'd1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (20) @(posedge clk);
        check("ignore_pending", sb_q.size(), 0);

        // Asynchronous reset mid-SHIFT aborts the conversion
        @(negedge clk);
        h = 2'd1; t = 4'd3; o = 4'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_busy", busy, 0);
        check("async_done", done, 0);
        check("async_err", err, 0);
        check("async_bin", bin, 0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        dcount = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) dcount++;
        end
        check("abort_no_done", dcount, 0);
        conv(2'd0, 4'd1, 4'd2, 1'b0, 8'h0C, 9, "c012");

        // start held high: back-to-back conversions every 10 cycles
        @(negedge clk);
        h = 2'd1; t = 4'd2; o = 4'd8; start = 1'b1;
        repeat (3) sb_q.push_back({1'b0, 8'h80});
        for (int k = 0; k < 3; k++) begin
            n = 0;
            do begin
                @(posedge clk);
                #1;
                n++;
            end while (done !== 1'b1 && n < 40);
            check("b2b_interval", n, 10);
        end
        start = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        check("scoreboard_empty", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
